// File: rtl/evg_dbus_pkg.sv
// evg_dbus_pkg
// Shared definitions for the event-generator distributed-bus source:
//   - cfgSelect register encodings
//   - bit positions inside the per-channel control register
//   - helper that turns the clock and ping rates into a ping period in cycles
package evg_dbus_pkg;

    typedef enum logic [1:0] {
        CFG_PERIOD   = 2'd0,
        CFG_WIDTH    = 2'd1,
        CFG_CONTROL  = 2'd2,
        CFG_RESERVED = 2'd3
    } cfgSelect_e;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_SYNC_BIT   = 1;

    // Number of transmit clock cycles between two ping pulses.
    function automatic int pingPeriod(input longint txClkHz, input longint pingHz);
        return int'(txClkHz / pingHz);
    endfunction

endpackage

// File: rtl/evg_dbus_channel.sv
// evg_dbus_channel
// One programmable periodic pulse train of the distributed bus.
// Ports:
//   evgTxClk, evgTxRst_n      transmit clock, async active-low reset
//   heartbeatRequest          one-cycle heartbeat request (phase sync source)
//   periodWrite/widthWrite    write strobes for the shadow period / width
//   controlWrite              write strobe for enable and syncOnHeartbeat
//   cfgData                   write data shared by all strobes
//   shadowPeriod/shadowWidth  shadow registers, exposed for readback
//   enable/syncOnHeartbeat    control bits, exposed for readback
//   channelOut                registered pulse output (one bus bit)
module evg_dbus_channel
    import evg_dbus_pkg::*;
#(
    parameter int COUNTER_WIDTH = 24
) (
    input  logic                     evgTxClk,
    input  logic                     evgTxRst_n,
    input  logic                     heartbeatRequest,
    input  logic                     periodWrite,
    input  logic                     widthWrite,
    input  logic                     controlWrite,
    input  logic [COUNTER_WIDTH-1:0] cfgData,
    output logic [COUNTER_WIDTH-1:0] shadowPeriod,
    output logic [COUNTER_WIDTH-1:0] shadowWidth,
    output logic                     enable,
    output logic                     syncOnHeartbeat,
    output logic                     channelOut
);

    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] TWO = COUNTER_WIDTH'(2);

    logic [COUNTER_WIDTH-1:0] activePeriod;
    logic [COUNTER_WIDTH-1:0] activeWidth;
    logic [COUNTER_WIDTH-1:0] phase;
    logic [COUNTER_WIDTH-1:0] effPhase;
    logic [COUNTER_WIDTH-1:0] phaseNext;
    logic                     periodValid;
    logic                     enableRise;
    logic                     syncEvent;
    logic                     atWrap;
    logic                     loadActive;

    // A sync event makes the current cycle behave as phase 0, so the
    // output flop produces the rising edge together with heartbeat bit 0
    // and the sync wins over a wrap landing on the same cycle. Periods
    // below 2 are treated as "off" and keep reloading from the shadow.
    always_comb begin
        periodValid = (activePeriod >= TWO);
        enableRise  = controlWrite && cfgData[CTRL_ENABLE_BIT] && !enable;
        syncEvent   = enable && syncOnHeartbeat && heartbeatRequest;
        effPhase    = syncEvent ? '0 : phase;
        atWrap      = (effPhase == (activePeriod - ONE));
        loadActive  = enableRise || syncEvent || !periodValid || (enable && atWrap);
        phaseNext   = effPhase + ONE;
        if (!enable || !periodValid || atWrap) begin
            phaseNext = '0;
        end
    end

    // Shadow and control registers are written directly by the config port.
    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            shadowPeriod    <= '0;
            shadowWidth     <= '0;
            enable          <= 1'b0;
            syncOnHeartbeat <= 1'b0;
        end else begin
            if (periodWrite) begin
                shadowPeriod <= cfgData;
            end
            if (widthWrite) begin
                shadowWidth <= cfgData;
            end
            if (controlWrite) begin
                enable          <= cfgData[CTRL_ENABLE_BIT];
                syncOnHeartbeat <= cfgData[CTRL_SYNC_BIT];
            end
        end
    end

    // Active registers sample the pre-write shadow values at a boundary,
    // so a write landing on a boundary only takes effect at the next one.
    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            activePeriod <= '0;
            activeWidth  <= '0;
            phase        <= '0;
            channelOut   <= 1'b0;
        end else begin
            if (loadActive) begin
                activePeriod <= shadowPeriod;
                activeWidth  <= shadowWidth;
            end
            phase      <= phaseNext;
            channelOut <= enable && periodValid && (effPhase < activeWidth);
        end
    end

endmodule

// File: rtl/evg_dbus_generator.sv
// evg_dbus_generator
// Distributed-bus source for the event generator.
//   bit 0                  heartbeat request delayed one cycle
//   bit 1                  ping pulse every PING_PERIOD cycles
//   bits 2..CHANNEL_COUNT+1 programmable periodic pulse trains
//   higher bits            tied low
// Ports:
//   evgTxClk, evgTxRst_n   transmit clock, async active-low reset
//   evgHeartbeatRequest    one-cycle heartbeat request
//   cfgWrite               one-cycle configuration write strobe
//   cfgChannel, cfgSelect  register address (channel, period/width/control)
//   cfgData                write data
//   cfgReadData            registered readback of the addressed register
//   evgDistributedBus      registered distributed bus
module evg_dbus_generator
    import evg_dbus_pkg::*;
#(
    parameter int TXCLK_NOMINAL_FREQUENCY = 125000000,
    parameter int PING_FREQUENCY          = 100000,
    parameter int DISTRIBUTED_BUS_WIDTH   = 8,
    parameter int CHANNEL_COUNT           = 6,
    parameter int COUNTER_WIDTH           = 24
) (
    input  logic                             evgTxClk,
    input  logic                             evgTxRst_n,
    input  logic                             evgHeartbeatRequest,
    input  logic                             cfgWrite,
    input  logic [$clog2(CHANNEL_COUNT)-1:0] cfgChannel,
    input  logic [1:0]                       cfgSelect,
    input  logic [COUNTER_WIDTH-1:0]         cfgData,
    output logic [COUNTER_WIDTH-1:0]         cfgReadData,
    output logic [DISTRIBUTED_BUS_WIDTH-1:0] evgDistributedBus
);

    localparam int CHANNEL_SEL_WIDTH = $clog2(CHANNEL_COUNT);
    localparam int PING_PERIOD       = pingPeriod(TXCLK_NOMINAL_FREQUENCY, PING_FREQUENCY);
    localparam int PING_WIDTH        = (PING_PERIOD > 1) ? $clog2(PING_PERIOD) : 1;
    localparam logic [PING_WIDTH-1:0] PING_RELOAD = PING_WIDTH'(PING_PERIOD - 1);

    if (DISTRIBUTED_BUS_WIDTH < 2 || CHANNEL_COUNT > DISTRIBUTED_BUS_WIDTH - 2) begin : gParamCheck
        $error("evg_dbus_generator: CHANNEL_COUNT does not fit in DISTRIBUTED_BUS_WIDTH-2 bits");
    end

    logic [COUNTER_WIDTH-1:0] shadowPeriodArr [CHANNEL_COUNT];
    logic [COUNTER_WIDTH-1:0] shadowWidthArr  [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0] enableVec;
    logic [CHANNEL_COUNT-1:0] syncVec;
    logic [CHANNEL_COUNT-1:0] channelOutVec;
    logic [PING_WIDTH-1:0]    pingCounter;
    logic                     pingReg;
    logic                     heartbeatReg;
    logic [COUNTER_WIDTH-1:0] readNext;

    // Writes to channels at or above CHANNEL_COUNT never match any instance.
    for (genvar k = 0; k < CHANNEL_COUNT; k++) begin : gChannel
        logic channelHit;
        assign channelHit = cfgWrite && (cfgChannel == CHANNEL_SEL_WIDTH'(k));

        evg_dbus_channel #(
            .COUNTER_WIDTH(COUNTER_WIDTH)
        ) uChannel (
            .evgTxClk        (evgTxClk),
            .evgTxRst_n      (evgTxRst_n),
            .heartbeatRequest(evgHeartbeatRequest),
            .periodWrite     (channelHit && (cfgSelect == CFG_PERIOD)),
            .widthWrite      (channelHit && (cfgSelect == CFG_WIDTH)),
            .controlWrite    (channelHit && (cfgSelect == CFG_CONTROL)),
            .cfgData         (cfgData),
            .shadowPeriod    (shadowPeriodArr[k]),
            .shadowWidth     (shadowWidthArr[k]),
            .enable          (enableVec[k]),
            .syncOnHeartbeat (syncVec[k]),
            .channelOut      (channelOutVec[k])
        );
    end

    // Heartbeat delay and free-running ping down-counter; the ping flag is
    // raised on the cycle after the counter sits at zero.
    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            heartbeatReg <= 1'b0;
            pingReg      <= 1'b0;
            pingCounter  <= PING_RELOAD;
        end else begin
            heartbeatReg <= evgHeartbeatRequest;
            pingReg      <= (pingCounter == '0);
            if (pingCounter == '0) begin
                pingCounter <= PING_RELOAD;
            end else begin
                pingCounter <= pingCounter - PING_WIDTH'(1);
            end
        end
    end

    // Readback mux over the shadow registers; unknown addresses read zero.
    always_comb begin
        readNext = '0;
        if (int'(cfgChannel) < CHANNEL_COUNT) begin
            case (cfgSelect_e'(cfgSelect))
                CFG_PERIOD:  readNext = shadowPeriodArr[cfgChannel];
                CFG_WIDTH:   readNext = shadowWidthArr[cfgChannel];
                CFG_CONTROL: begin
                    readNext[CTRL_ENABLE_BIT] = enableVec[cfgChannel];
                    readNext[CTRL_SYNC_BIT]   = syncVec[cfgChannel];
                end
                default:     readNext = '0;
            endcase
        end
    end

    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            cfgReadData <= '0;
        end else begin
            cfgReadData <= readNext;
        end
    end

    // Every bus bit comes straight from a flop, so the bus is registered.
    always_comb begin
        evgDistributedBus                     = '0;
        evgDistributedBus[0]                  = heartbeatReg;
        evgDistributedBus[1]                  = pingReg;
        evgDistributedBus[CHANNEL_COUNT+1:2]  = channelOutVec;
    end

endmodule

// File: tb/tb_evg_dbus_generator.sv
// tb_evg_dbus_generator
// Directed bench for evg_dbus_generator with default parameters
// (ping period 1250 cycles, 8-bit bus, 6 channels, 24-bit counters).
module tb_evg_dbus_generator;

    logic        evgTxClk = 1'b0;
    logic        evgTxRst_n;
    logic        evgHeartbeatRequest;
    logic        cfgWrite;
    logic [2:0]  cfgChannel;
    logic [1:0]  cfgSelect;
    logic [23:0] cfgData;
    logic [23:0] cfgReadData;
    logic [7:0]  evgDistributedBus;

    int passCount  = 0;
    int checkCount = 0;

    int hbCount, hbAt, pingCount, pingAt1, pingAt2, otherBits;
    logic [63:0] observedVec;
    logic [63:0] expectedVec;
    logic [5:0]  channelAccum;

    evg_dbus_generator dut (
        .evgTxClk           (evgTxClk),
        .evgTxRst_n         (evgTxRst_n),
        .evgHeartbeatRequest(evgHeartbeatRequest),
        .cfgWrite           (cfgWrite),
        .cfgChannel         (cfgChannel),
        .cfgSelect          (cfgSelect),
        .cfgData            (cfgData),
        .cfgReadData        (cfgReadData),
        .evgDistributedBus  (evgDistributedBus)
    );

    always #5 evgTxClk = ~evgTxClk;

    // Drive one cycle's inputs, let one rising edge pass, settle 1 ns after it.
    task automatic applyStimulus(input logic hb, input logic wr, input logic [2:0] ch,
                                 input logic [1:0] sel, input logic [23:0] data);
        evgHeartbeatRequest = hb;
        cfgWrite            = wr;
        cfgChannel          = ch;
        cfgSelect           = sel;
        cfgData             = data;
        @(posedge evgTxClk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    initial begin
        evgTxRst_n = 1'b0;
        evgHeartbeatRequest = 1'b0;
        cfgWrite = 1'b0;
        cfgChannel = 3'd0;
        cfgSelect = 2'd0;
        cfgData = 24'd0;
        repeat (3) @(posedge evgTxClk);
        #1;
        checkOutput("resetBus", 64'(evgDistributedBus), 64'd0);
        checkOutput("resetRead", 64'(cfgReadData), 64'd0);
        @(negedge evgTxClk);
        evgTxRst_n = 1'b1;

        // Default run: ping spacing and a single heartbeat at cycle 101.
        hbCount = 0; hbAt = 0; pingCount = 0; pingAt1 = 0; pingAt2 = 0; otherBits = 0;
        for (int c = 1; c <= 3000; c++) begin
            applyStimulus(c == 101, 1'b0, 3'd0, 2'd0, 24'd0);
            if (evgDistributedBus[0]) begin
                hbCount++;
                hbAt = c;
            end
            if (evgDistributedBus[1]) begin
                pingCount++;
                if (pingCount == 1) pingAt1 = c;
                if (pingCount == 2) pingAt2 = c;
            end
            if (evgDistributedBus[7:2] != 6'd0) otherBits++;
        end
        checkOutput("hbCount", 64'(hbCount), 64'd1);
        checkOutput("hbCycle", 64'(hbAt), 64'd101);
        checkOutput("pingCount", 64'(pingCount), 64'd2);
        checkOutput("pingFirst", 64'(pingAt1), 64'd1250);
        checkOutput("pingSecond", 64'(pingAt2), 64'd2500);
        checkOutput("idleChannels", 64'(otherBits), 64'd0);

        // Channel 0: period 10, width 3, then enable.
        applyStimulus(1'b0, 1'b1, 3'd0, 2'd0, 24'd10);
        applyStimulus(1'b0, 1'b1, 3'd0, 2'd1, 24'd3);
        applyStimulus(1'b0, 1'b1, 3'd0, 2'd2, 24'd1);
        checkOutput("ch0LowOnEnableCycle", 64'(evgDistributedBus[2]), 64'd0);
        observedVec = '0; expectedVec = '0;
        for (int j = 1; j <= 20; j++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
            observedVec[j-1] = evgDistributedBus[2];
            expectedVec[j-1] = ((j - 1) % 10) < 3;
        end
        checkOutput("ch0Pattern3of10", observedVec, expectedVec);

        // Period rewritten to 20 at phase 0: current 10-cycle period completes first.
        observedVec = '0; expectedVec = '0;
        for (int j = 1; j <= 35; j++) begin
            applyStimulus(1'b0, j == 1, 3'd0, 2'd0, 24'd20);
            observedVec[j-1] = evgDistributedBus[2];
            expectedVec[j-1] = (j <= 10) ? ((j - 1) < 3) : (((j - 11) % 20) < 3);
        end
        checkOutput("ch0PeriodChange", observedVec, expectedVec);

        // Period rewritten to 10 exactly on the wrap cycle: one extra 20-cycle period.
        observedVec = '0; expectedVec = '0;
        for (int k = 1; k <= 46; k++) begin
            int rel;
            applyStimulus(1'b0, k == 15, 3'd0, 2'd0, 24'd10);
            rel = k + 55 - 71;
            observedVec[k-1] = evgDistributedBus[2];
            if (rel >= 0 && rel < 20) expectedVec[k-1] = rel < 3;
            else if (rel >= 20)       expectedVec[k-1] = ((rel - 20) % 10) < 3;
        end
        checkOutput("ch0WrapWriteDefers", observedVec, expectedVec);

        // Readback of shadow/control registers and ignored writes.
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
        checkOutput("readCh0Period", 64'(cfgReadData), 64'd10);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd1, 24'd0);
        checkOutput("readCh0Width", 64'(cfgReadData), 64'd3);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd2, 24'd0);
        checkOutput("readCh0Control", 64'(cfgReadData), 64'd1);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd3, 24'd0);
        checkOutput("readReserved", 64'(cfgReadData), 64'd0);
        applyStimulus(1'b0, 1'b1, 3'd6, 2'd0, 24'd77);
        checkOutput("readOutOfRange", 64'(cfgReadData), 64'd0);
        applyStimulus(1'b0, 1'b1, 3'd0, 2'd3, 24'hFFFFFF);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
        checkOutput("reservedWriteIgnoredP", 64'(cfgReadData), 64'd10);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd1, 24'd0);
        checkOutput("reservedWriteIgnoredW", 64'(cfgReadData), 64'd3);

        // Channel 1: period 7, width 1, enable + syncOnHeartbeat.
        applyStimulus(1'b0, 1'b1, 3'd1, 2'd0, 24'd7);
        applyStimulus(1'b0, 1'b1, 3'd1, 2'd1, 24'd1);
        applyStimulus(1'b0, 1'b1, 3'd1, 2'd2, 24'd3);
        applyStimulus(1'b0, 1'b0, 3'd1, 2'd2, 24'd0);
        checkOutput("ch1FirstPulse", 64'(evgDistributedBus[3]), 64'd1);
        checkOutput("readCh1Control", 64'(cfgReadData), 64'd3);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
        checkOutput("ch1LowBeforeSync", 64'(evgDistributedBus[3]), 64'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 2'd0, 24'd0);
        checkOutput("syncHbBit", 64'(evgDistributedBus[0]), 64'd1);
        checkOutput("syncCh1Bit", 64'(evgDistributedBus[3]), 64'd1);
        observedVec = '0; expectedVec = '0;
        for (int k = 1; k <= 14; k++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
            observedVec[k-1] = evgDistributedBus[3];
            expectedVec[k-1] = (k % 7) == 0;
        end
        checkOutput("ch1AfterSync", observedVec, expectedVec);

        // Width 0 gives constant low, width equal to period gives constant high.
        applyStimulus(1'b0, 1'b1, 3'd1, 2'd1, 24'd0);
        repeat (10) applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
        observedVec = '0;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
            observedVec[k] = evgDistributedBus[3];
        end
        checkOutput("ch1Width0", observedVec, 64'h0);
        applyStimulus(1'b0, 1'b1, 3'd1, 2'd1, 24'd7);
        repeat (10) applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
        observedVec = '0;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
            observedVec[k] = evgDistributedBus[3];
        end
        checkOutput("ch1Width7", observedVec, 64'h7F);

        // Reset mid-pulse clears the bus asynchronously.
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd2, 24'd0);
        checkOutput("ch1HighBeforeReset", 64'(evgDistributedBus[3]), 64'd1);
        #2;
        evgTxRst_n = 1'b0;
        #1;
        checkOutput("busAsyncReset", 64'(evgDistributedBus), 64'd0);
        checkOutput("readAsyncReset", 64'(cfgReadData), 64'd0);
        repeat (2) @(negedge evgTxClk);
        evgTxRst_n = 1'b1;
        channelAccum = '0;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
            channelAccum = channelAccum | evgDistributedBus[7:2];
        end
        checkOutput("channelsOffAfterReset", 64'(channelAccum), 64'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd2, 24'd0);
        checkOutput("ch0ControlCleared", 64'(cfgReadData), 64'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 24'd0);
        checkOutput("ch0PeriodCleared", 64'(cfgReadData), 64'd0);
        applyStimulus(1'b0, 1'b0, 3'd1, 2'd1, 24'd0);
        checkOutput("ch1WidthCleared", 64'(cfgReadData), 64'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
